// File: rtl/phy_rx_deserializer_pkg.sv
// Shared PHY constants and receive-FSM encoding, reused by the TX serializer and the tester.
package phy_rx_deserializer_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] IDL_SYM = 8'h7C;

  // Encoding 2'd3 is unused and is treated as SEARCH by the receiver.
  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    COUNT_COM = 2'd1,
    ACTIVE    = 2'd2
  } rx_state_e;

  function automatic logic is_data_sym(input logic [7:0] sym,
                                       input logic [7:0] com,
                                       input logic [7:0] idl);
    return (sym != com) && (sym != idl);
  endfunction

endpackage

// File: rtl/phy_rx_deserializer_if.sv
// Serial lane in, aligned byte stream out; master drives the lane, slave is the deserializer.
interface phy_rx_deserializer_if;

  logic       data_serial;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output data_serial,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  data_serial,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );

endinterface

// File: rtl/phy_rx_deserializer.sv
// Serial-to-parallel receive stage: locks byte alignment on a run of COM symbols, then emits bytes.
module phy_rx_deserializer
  import phy_rx_deserializer_pkg::*;
#(
  parameter logic [7:0] COM_SYM_P = COM_SYM,
  parameter logic [7:0] IDL_SYM_P = IDL_SYM,
  parameter int         COM_COUNT = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  phy_rx_deserializer_if.slave  rx
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  rx_state_e  state_q;
  logic [7:0] sr_q;
  logic [7:0] sr_d;
  logic [2:0] bit_cnt_q;
  logic [3:0] com_cnt_q;
  logic [3:0] com_cnt_d;
  logic [7:0] data_out_q;
  logic       valid_q;
  logic       strobe_q;
  logic       active_q;

  assign sr_d      = {sr_q[6:0], rx.data_serial};
  assign com_cnt_d = (com_cnt_q == 4'hF) ? 4'hF : com_cnt_q + 4'd1;

  // Boundary compares use sr_d so a byte is judged on the same edge that samples its last bit.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= SEARCH;
      sr_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      com_cnt_q  <= 4'd0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      strobe_q <= 1'b0;
      case (state_q)
        COUNT_COM: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (sr_d == COM_SYM_P) begin
              com_cnt_q <= com_cnt_d;
              if (com_cnt_d == COM_TARGET) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              state_q   <= SEARCH;
              com_cnt_q <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_out_q <= sr_d;
            strobe_q   <= 1'b1;
            valid_q    <= is_data_sym(sr_d, COM_SYM_P, IDL_SYM_P);
          end
        end
        default: begin
          state_q <= SEARCH;
          if (sr_d == COM_SYM_P) begin
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd1;
            if (COM_COUNT == 1) begin
              state_q  <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state_q <= COUNT_COM;
            end
          end
        end
      endcase
    end
  end

  assign rx.data_out    = data_out_q;
  assign rx.valid_out   = valid_q;
  assign rx.byte_strobe = strobe_q;
  assign rx.active      = active_q;

endmodule
